poly_tone: RTL and testbench

POLY_TONE -- requirements
Module: poly_tone

---
 rtl/poly_tone.sv | 139 +++++++++++++
 tb/tb_poly_tone.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/poly_tone.sv
// Time-multiplexed polyphonic tone generator: square/saw/triangle voices mixed per scan.
// Define POLY_TONE_ENVELOPE_EN for per-voice linear attack/release ramps.
module poly_tone #(
  parameter int VOICES     = 4,
  parameter int RESOLUTION = 14,
  parameter int PHASEWIDTH = 32,
  parameter int ENVWIDTH   = 8,
  parameter int RAMP_DIV   = 2500
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [$clog2(VOICES)-1:0]  cfg_voice,
  input  logic [PHASEWIDTH-1:0]      cfg_fsel,
  input  logic [1:0]                 cfg_mode,
  input  logic                       cfg_sync,
  input  logic [VOICES-1:0]          gate,
  output logic [RESOLUTION-1:0]      audio,
  output logic                       audio_stb
);

  localparam int LV = $clog2(VOICES);
  localparam int AW = RESOLUTION + LV + 1;
  localparam int PW = RESOLUTION + ENVWIDTH + 2;
  localparam logic [RESOLUTION-1:0] MID =
    {1'b1, {(RESOLUTION-1){1'b0}}};

  logic [PHASEWIDTH-1:0] phase [VOICES];
  logic [PHASEWIDTH-1:0] fsel  [VOICES];
  logic [1:0]            mode  [VOICES];
  logic [ENVWIDTH-1:0]   env   [VOICES];
  logic [LV-1:0]         idx;
  logic signed [AW-1:0]  acc;

  logic [RESOLUTION-1:0]    p;
  logic [RESOLUTION-1:0]    wave;
  logic signed [RESOLUTION:0] dev;
  logic signed [PW-1:0]     prod;
  logic signed [RESOLUTION:0] s;
  logic signed [AW-1:0]     sum;
  logic signed [AW-1:0]     avg;
  logic signed [AW:0]       lvl;
  logic [RESOLUTION-1:0]    sat;
  logic                     take;
  logic                     unused_bits;

  assign take = cfg_valid && cfg_ready;

  always_comb begin
    p    = phase[idx][PHASEWIDTH-1 -: RESOLUTION];
    wave = MID;
    unique case (mode[idx])
      2'd0: wave = p[RESOLUTION-1] ? '0 : '1;
      2'd1: wave = p;
      2'd2: wave = p[RESOLUTION-1] ? (~p) << 1 : p << 1;
      default: wave = MID;
    endcase
    dev  = $signed({1'b0, wave}) - $signed({1'b0, MID});
    prod = dev * $signed({1'b0, env[idx]});
    // floor(d*env / 2^ENVWIDTH) always fits back into the deviation width
    s    = $signed(prod[RESOLUTION+ENVWIDTH:ENVWIDTH]);
    sum  = acc + $signed({{LV{s[RESOLUTION]}}, s});
    avg  = sum >>> LV;
    lvl  = $signed({avg[AW-1], avg})
         + $signed({{(LV+2){1'b0}}, MID});
    if (lvl < 0)
      sat = '0;
    else if (lvl > $signed({{(LV+2){1'b0}}, {RESOLUTION{1'b1}}}))
      sat = '1;
    else
      sat = lvl[RESOLUTION-1:0];
  end

  assign unused_bits = ^{prod[PW-1], prod[ENVWIDTH-1:0]};

`ifdef POLY_TONE_ENVELOPE_EN
  localparam int CW = $clog2(RAMP_DIV + 1);
  logic [CW-1:0] pre;
  logic          tick;

  assign tick = (pre == CW'(RAMP_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)
      pre <= '0;
    else
      pre <= tick ? '0 : pre + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < VOICES; i++) begin
        phase[i] <= '0;
        fsel[i]  <= '0;
        mode[i]  <= '0;
        env[i]   <= '0;
      end
      idx       <= '0;
      acc       <= '0;
      audio     <= MID;
      audio_stb <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      phase[idx] <= phase[idx] + fsel[idx];
`ifdef POLY_TONE_ENVELOPE_EN
      if (tick) begin
        for (int i = 0; i < VOICES; i++) begin
          if (gate[i] && env[i] != '1)
            env[i] <= env[i] + 1'b1;
          else if (!gate[i] && env[i] != '0)
            env[i] <= env[i] - 1'b1;
        end
      end
`else
      env[idx] <= gate[idx] ? '1 : '0;
`endif
      idx <= idx + 1'b1;
      if (idx == LV'(VOICES - 1)) begin
        acc       <= '0;
        audio     <= sat;
        audio_stb <= 1'b1;
      end else begin
        acc       <= sum;
        audio_stb <= 1'b0;
      end
      cfg_ready <= !take;
      // a write lands after the scan update so sync beats the advance
      if (take) begin
        fsel[cfg_voice] <= cfg_fsel;
        mode[cfg_voice] <= cfg_mode;
        if (cfg_sync)
          phase[cfg_voice] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_poly_tone.sv
// Randomized scoreboard bench for poly_tone (default build, envelope macro off).
// A scan-level reference model predicts every audio sample.
module tb_poly_tone;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_voice;
  logic [31:0] cfg_fsel;
  logic [1:0]  cfg_mode;
  logic        cfg_sync;
  logic [3:0]  gate;
  logic [13:0] audio;
  logic        audio_stb;

  poly_tone dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_voice(cfg_voice), .cfg_fsel(cfg_fsel),
    .cfg_mode(cfg_mode), .cfg_sync(cfg_sync),
    .gate(gate), .audio(audio), .audio_stb(audio_stb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int expq[$];

  longint unsigned m_ph[4];
  longint unsigned m_fs[4];
  int m_md[4];
  int m_ev[4];
  int m_vis;
  int m_acc;
  bit m_rdy;

  function automatic int fdiv(int a, int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic int voice_wave(int v);
    int p;
    p = int'(m_ph[v] >> 18);
    case (m_md[v])
      0: return (m_ph[v] < 64'h8000_0000) ? 16383 : 0;
      1: return p;
      2: return (p < 8192) ? 2 * p : 2 * (16383 - p);
      default: return 8192;
    endcase
  endfunction

  // Predict the effect of the coming clock edge from the current inputs.
  task automatic model_step();
    int v, s, lv;
    bit acc_ok;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_ph[i] = 0; m_fs[i] = 0; m_md[i] = 0; m_ev[i] = 0;
      end
      m_vis = 0; m_acc = 0; m_rdy = 0;
      return;
    end
    v = m_vis;
    s = fdiv((voice_wave(v) - 8192) * m_ev[v], 256);
    m_acc += s;
    m_ph[v] = (m_ph[v] + m_fs[v]) & 64'hFFFF_FFFF;
    m_ev[v] = gate[v] ? 255 : 0;
    acc_ok = cfg_valid && m_rdy;
    if (acc_ok) begin
      m_fs[cfg_voice] = cfg_fsel;
      m_md[cfg_voice] = cfg_mode;
      if (cfg_sync) m_ph[cfg_voice] = 0;
    end
    m_rdy = !acc_ok;
    if (v == 3) begin
      lv = 8192 + fdiv(m_acc, 4);
      if (lv < 0) lv = 0;
      if (lv > 16383) lv = 16383;
      expq.push_back(lv);
      m_acc = 0;
    end
    m_vis = (v + 1) % 4;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    chk("cfg_ready", int'(cfg_ready), int'(m_rdy));
  endtask

  task automatic cfg_write(int v, int unsigned f, int m, bit sy);
    int n = 0;
    while (!m_rdy && n < 10) begin
      tick();
      n++;
    end
    if (!m_rdy) chk("cfg_ready_timeout", 0, 1);
    cfg_valid = 1'b1;
    cfg_voice = 2'(v);
    cfg_fsel  = f;
    cfg_mode  = 2'(m);
    cfg_sync  = sy;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Monitor: scoreboard, strobe cadence, reset values, level tracking.
  int cyc = 0;
  int last_stb = 0;
  bit trk = 0;
  int hi_val, lo_val;
  bit seen_hi, seen_lo, seen_oth;
  int last_chg, last_val;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst_n) begin
      chk("rst_audio", int'(audio), 8192);
      chk("rst_stb", int'(audio_stb), 0);
      chk("rst_ready", int'(cfg_ready), 0);
      last_stb = 0;
    end else if (audio_stb) begin
      if (expq.size() == 0) begin
        chk("unexpected_stb", 1, 0);
      end else begin
        chk("audio", int'(audio), expq.pop_front());
      end
      if (last_stb != 0) chk("stb_period", cyc - last_stb, 4);
      last_stb = cyc;
      if (trk) begin
        if (int'(audio) == hi_val) seen_hi = 1;
        else if (int'(audio) == lo_val) seen_lo = 1;
        else seen_oth = 1;
        if (int'(audio) != last_val) begin
          if (last_chg != 0 && lo_val == 6152)
            chk("half_period", cyc - last_chg, 512);
          last_chg = cyc;
          last_val = int'(audio);
        end
      end
    end
  end

  task automatic track_start(int h, int l);
    hi_val = h; lo_val = l;
    seen_hi = 0; seen_lo = 0; seen_oth = 0;
    last_chg = 0; last_val = int'(audio);
    trk = 1;
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_voice = '0;
    cfg_fsel = '0; cfg_mode = '0; cfg_sync = 1'b0; gate = '0;
    m_rdy = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("ready_after_release", int'(cfg_ready), 1);
    repeat (20) tick();

    // single square voice
    gate = 4'b0001;
    repeat (8) tick();
    cfg_write(0, 32'h0100_0000, 0, 1'b1);
    repeat (8) tick();
    track_start(10231, 6152);
    repeat (2100) tick();
    trk = 0;
    chk("sq1_seen_hi", int'(seen_hi), 1);
    chk("sq1_seen_lo", int'(seen_lo), 1);
    chk("sq1_other", int'(seen_oth), 0);

    // four voices in unison reach the extremes without wrapping
    gate = 4'b1111;
    for (int v = 0; v < 4; v++) cfg_write(v, 32'h0100_0000, 0, 1'b1);
    repeat (8) tick();
    track_start(16351, 32);
    repeat (1200) tick();
    trk = 0;
    chk("sq4_seen_hi", int'(seen_hi), 1);
    chk("sq4_seen_lo", int'(seen_lo), 1);

    // held cfg_valid: handshake alternates
    tick();
    cfg_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_voice = 2'(m_vis);
      cfg_fsel  = $urandom;
      cfg_mode  = 2'(i);
      cfg_sync  = 1'b0;
      chk("hold_ready", int'(cfg_ready), (i % 2 == 0) ? 1 : 0);
      tick();
    end
    cfg_valid = 1'b0;
    repeat (40) tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_voice = 2'($urandom_range(0, 3));
      cfg_fsel  = $urandom >> $urandom_range(0, 12);
      cfg_mode  = 2'($urandom_range(0, 3));
      cfg_sync  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) gate = 4'($urandom);
      tick();
    end
    cfg_valid = 1'b0;

    // reset in the middle of a scan
    while (m_vis != 2) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("ready_after_midreset", int'(cfg_ready), 1);
    gate = 4'b0110;
    cfg_write(1, 32'h0300_0000, 2, 1'b1);
    cfg_write(2, 32'h0050_0000, 1, 1'b0);
    repeat (600) tick();

    chk("queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
